ej32_fetch_q: RTL

- Parametrised instruction prefetch queue for eJ32; replaces the simple `p + p_inc` instruction pointer.
- Streams opcode bytes from the shared 8-bit memory bus into a ring buffer.
- Presents a WIN-byte window (opcode plus operand bytes) to the decoder.
- Decoder consumes 0..WIN bytes per cycle. A branch flushes the queue and redirects fetch.

---
 rtl/ej32_fetch_q_pkg.sv | 19 +
 rtl/ej32_fetch_q_if.sv | 26 ++
 rtl/ej32_fetch_q_ring.sv | 61 ++++++
 rtl/ej32_fetch_q.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/ej32_fetch_q_pkg.sv
// Shared types and defaults for the eJ32 instruction prefetch queue.
// Imported by the ring storage and the fetch-queue top level.
package ej32_fetch_q_pkg;

    localparam int FQ_DEPTH = 8;
    localparam int FQ_WIN   = 4;

    typedef logic [$clog2(FQ_DEPTH)-1:0] fq_ptr_t;

    typedef enum logic {
        FQ_FLUSH = 1'b0,
        FQ_RUN   = 1'b1
    } fq_state_e;

    function automatic int fq_min(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/ej32_fetch_q_if.sv
// Shared 8-bit memory bus seen by the prefetch queue: request/address out,
// grant and one-cycle-late read data back.
interface ej32_fetch_q_if #(
    parameter int ASZ = 17
) ();

    logic           mem_req;
    logic [ASZ-1:0] mem_a;
    logic           mem_gnt;
    logic [7:0]     mem_d;

    modport master (
        output mem_req,
        output mem_a,
        input  mem_gnt,
        input  mem_d
    );

    modport slave (
        input  mem_req,
        input  mem_a,
        output mem_gnt,
        output mem_d
    );

endinterface

// File: rtl/ej32_fetch_q_ring.sv
// DEPTH x 8 ring buffer: single-byte push, multi-byte pop and a WIN-byte
// read window starting at the head; bytes beyond the occupancy read as zero.
module ej32_fq_ring
    import ej32_fetch_q_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int WIN   = FQ_WIN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_wr_en,
    input  logic [7:0]                 i_wr_d,
    input  logic [$clog2(WIN+1)-1:0]   i_pop_n,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt,
    output logic [8*WIN-1:0]           o_win
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_rd;
    logic [PW-1:0] r_wr;
    logic [CW-1:0] r_cnt;

    // Storage has no reset: stale bytes are masked by the occupancy count.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[r_wr] <= i_wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_wr_en) begin
                r_wr <= r_wr + PW'(1'b1);
            end
            r_rd  <= r_rd + PW'(i_pop_n);
            r_cnt <= r_cnt + CW'(i_wr_en) - CW'(i_pop_n);
        end
    end

    always_comb begin
        o_win = '0;
        for (int i = 0; i < WIN; i++) begin
            if (CW'(i) < r_cnt) begin
                o_win[8*i +: 8] = r_mem[r_rd + PW'(i)];
            end else begin
                o_win[8*i +: 8] = 8'h00;
            end
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ej32_fetch_q.sv
// eJ32 instruction prefetch queue: streams opcode bytes from the shared bus
// into a ring and presents a WIN-byte window to the decoder. Define
// EJ32_FQ_BYPASS_EN to forward a byte returning into an empty queue straight
// to window byte 0 in its return cycle.
module ej32_fetch_q
    import ej32_fetch_q_pkg::*;
#(
    parameter int unsigned COLD  = 32'd0,
    parameter int          ASZ   = 17,
    parameter int          DEPTH = FQ_DEPTH,
    parameter int          WIN   = FQ_WIN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_br_psel,
    input  logic [ASZ-1:0]             i_br_p,
    input  logic [$clog2(WIN+1)-1:0]   i_pop_n,
    output logic [8*WIN-1:0]           o_win,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt,
    output logic [ASZ-1:0]             o_p,
    ej32_fetch_q_if.master             bus
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int NW = $clog2(WIN + 1);
    localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

    fq_state_e      r_state;
    fq_state_e      w_state_nxt;
    logic [ASZ-1:0] r_fa;
    logic [ASZ-1:0] r_p;
    logic           r_infl;

    logic           w_run;
    logic           w_req;
    logic           w_grant;
    logic           w_byp;
    logic           w_consume_byp;
    logic           w_wr_en;
    logic [CW-1:0]  w_ring_cnt;
    logic [CW-1:0]  w_cnt;
    logic [NW-1:0]  w_pop;
    logic [NW-1:0]  w_ring_pop;
    logic [8*WIN-1:0] w_ring_win;
    logic [8*WIN-1:0] w_win;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FQ_FLUSH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = FQ_FLUSH;
        case (r_state)
            FQ_FLUSH: w_state_nxt = i_br_psel ? FQ_FLUSH : FQ_RUN;
            FQ_RUN:   w_state_nxt = i_br_psel ? FQ_FLUSH : FQ_RUN;
            default:  w_state_nxt = FQ_FLUSH;
        endcase
    end

    // Counting the in-flight byte against capacity keeps the ring from overflowing.
    always_comb begin
        w_run = 1'b0;
        w_req = 1'b0;
        case (r_state)
            FQ_RUN: begin
                w_run = 1'b1;
                w_req = ({1'b0, w_ring_cnt} + {{CW{1'b0}}, r_infl}) < DEPTH_W;
            end
            FQ_FLUSH: begin
                w_run = 1'b0;
                w_req = 1'b0;
            end
            default: begin
                w_run = 1'b0;
                w_req = 1'b0;
            end
        endcase
    end

    assign w_grant = w_req && bus.mem_gnt;

`ifdef EJ32_FQ_BYPASS_EN
    assign w_byp = r_infl && (w_ring_cnt == '0);
`else
    assign w_byp = 1'b0;
`endif

    // A forwarded byte that is popped in its return cycle never enters the ring.
    always_comb begin
        w_cnt = w_ring_cnt + CW'(w_byp);
        if (w_run) begin
            w_pop = NW'(fq_min(int'(i_pop_n), int'(w_cnt)));
        end else begin
            w_pop = '0;
        end
        w_consume_byp = w_byp && (w_pop != '0);
        if (w_consume_byp) begin
            w_ring_pop = '0;
        end else begin
            w_ring_pop = w_pop;
        end
        w_wr_en = r_infl && !i_br_psel && !w_consume_byp;
        w_win   = w_ring_win;
        if (w_byp) begin
            w_win[7:0] = bus.mem_d;
        end else begin
            w_win[7:0] = w_ring_win[7:0];
        end
    end

    // Clearing r_infl on a branch discards the return that lands next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fa   <= ASZ'(COLD);
            r_p    <= ASZ'(COLD);
            r_infl <= 1'b0;
        end else if (i_br_psel) begin
            r_fa   <= i_br_p;
            r_p    <= i_br_p;
            r_infl <= 1'b0;
        end else begin
            if (w_grant) begin
                r_fa <= r_fa + ASZ'(1'b1);
            end
            r_infl <= w_grant;
            r_p    <= r_p + ASZ'(w_pop);
        end
    end

    ej32_fq_ring #(
        .DEPTH (DEPTH),
        .WIN   (WIN)
    ) u_ring (
        .clk     (clk),
        .rst     (rst),
        .i_flush (i_br_psel),
        .i_wr_en (w_wr_en),
        .i_wr_d  (bus.mem_d),
        .i_pop_n (w_ring_pop),
        .o_cnt   (w_ring_cnt),
        .o_win   (w_ring_win)
    );

    assign bus.mem_req = w_req;
    assign bus.mem_a   = r_fa;
    assign o_win       = w_win;
    assign o_cnt       = w_cnt;
    assign o_p         = r_p;

endmodule
